// File: rtl/alu_div_seq_if.sv
// alu_div_seq_if: start/done handshake bundle for the sequential divider.
//   start, dividend[9:0], divisor[4:0]     : requester -> divider
//   busy, done, quotient[9:0], remainder[4:0],
//   div_by_zero, ovf                       : divider -> requester
// master = requester side, slave = divider side.
interface alu_div_seq_if;
  localparam int unsigned DVD_W = 10;
  localparam int unsigned DVS_W = 5;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_by_zero;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, ovf
  );
endinterface

// File: rtl/alu_div_seq.sv
// alu_div_seq: 10-by-5-bit unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_div_seq_if.slave (start/dividend/divisor in;
//            busy/done/quotient/remainder/div_by_zero/ovf out, all registered)
// Optional feature: define ALU_DIV_OVF_CHECK_EN to drive ovf (final quotient > 31);
// without it ovf is tied to 0.
module alu_div_seq (
  input  logic          clk,
  input  logic          rst_n,
  alu_div_seq_if.slave  bus
);

  localparam int unsigned DVD_W     = 10;
  localparam int unsigned DVS_W     = 5;
  localparam int unsigned PREM_W    = DVS_W + 1;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LAST_STEP = DVD_W - 1;
  localparam int unsigned OPND_MAX  = (1 << DVS_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DVD_W-1:0]   dvd_q, dvd_d;
  logic [DVS_W-1:0]   dvs_q, dvs_d;
  logic [DVD_W-1:0]   quot_q, quot_d;
  logic [DVS_W-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PREM_W-1:0]  shifted;

  // Next-state and datapath; rem_q doubles as the running partial remainder,
  // which always stays below the divisor and so fits in 5 bits between steps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    shifted = {rem_q, dvd_q[DVD_W-1]};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            state_d = RUN;
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            cnt_d   = '0;
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend[DVS_W-1:0];
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (shifted >= PREM_W'(dvs_q)) begin
          rem_d  = DVS_W'(shifted - PREM_W'(dvs_q));
          quot_d = {quot_q[DVD_W-2:0], 1'b1};
        end else begin
          rem_d  = shifted[DVS_W-1:0];
          quot_d = {quot_q[DVD_W-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(LAST_STEP)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef ALU_DIV_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  // Cleared on any accepted start; set on the final step if the quotient
  // exceeds the 5-bit operand range. Divide-by-zero never reaches RUN, so it stays 0.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.start) begin
      ovf_d = 1'b0;
    end else if (state_q == RUN && cnt_q == CNT_W'(LAST_STEP)) begin
      ovf_d = (quot_d > DVD_W'(OPND_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: directed bench for alu_div_seq with a cycle-level reference model.
module tb_alu_div_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_seen;

  alu_div_seq_if bus ();

  alu_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ovf_of(input int q);
`ifdef ALU_DIV_OVF_CHECK_EN
    return q > 31;
`else
    return 1'b0 && (q > 31);
`endif
  endfunction

  // Reference model: cycles left until idle plus the arithmetic result of the
  // request in flight (integer divide / modulo).
  int          m_left;
  logic [9:0]  m_q;
  logic [4:0]  m_r;
  bit          m_dbz;
  bit          m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_q    = '0;
      m_r    = '0;
      m_dbz  = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (bus.start === 1'b1) begin
      if (bus.divisor == 5'd0) begin
        m_q    = 10'h3FF;
        m_r    = bus.dividend[4:0];
        m_dbz  = 1'b1;
        m_ovf  = 1'b0;
        m_left = 1;
      end else begin
        m_q    = 10'(int'(bus.dividend) / int'(bus.divisor));
        m_r    = 5'(int'(bus.dividend) % int'(bus.divisor));
        m_dbz  = 1'b0;
        m_ovf  = ovf_of(int'(m_q));
        m_left = 11;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done === 1'b1) done_seen++;
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("done", 32'(bus.done), 32'(m_left == 1));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
      if (m_left <= 1) begin
        chk("quotient", 32'(bus.quotient), 32'(m_q));
        chk("remainder", 32'(bus.remainder), 32'(m_r));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      end
    end
  end

  // Issue one request and wait (bounded) for done; check latency and literal results.
  task automatic run_div(input logic [9:0] a, input logic [4:0] b,
                         input logic [9:0] eq, input logic [4:0] er,
                         input bit edbz, input bit eovf, input int elat);
    int n;
    bit got;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      bus.start    = 1'b0;
      bus.dividend = 10'($urandom);
      bus.divisor  = 5'($urandom);
      if (bus.done === 1'b1) got = 1'b1;
    end
    chk("done_timeout", 32'(got), 32'd1);
    chk("latency", 32'(n), 32'(elat));
    chk("lit_quotient", 32'(bus.quotient), 32'(eq));
    chk("lit_remainder", 32'(bus.remainder), 32'(er));
    chk("lit_div_by_zero", 32'(bus.div_by_zero), 32'(edbz));
    chk("lit_ovf", 32'(bus.ovf), 32'(eovf));
  endtask

  initial begin
    int n;
    int d0, d1, dn;
    bit got;

    checks = 0;
    errors = 0;
    done_seen = 0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_div(10'd143, 5'd11, 10'd13, 5'd0, 1'b0, 1'b0, 11);
    run_div(10'd1000, 5'd7, 10'd142, 5'd6, 1'b0, ovf_of(142), 11);
    run_div(10'd1023, 5'd31, 10'd33, 5'd0, 1'b0, ovf_of(33), 11);
    run_div(10'd0, 5'd5, 10'd0, 5'd0, 1'b0, 1'b0, 11);
    run_div(10'd45, 5'd0, 10'h3FF, 5'd13, 1'b1, 1'b0, 1);
    run_div(10'd31, 5'd1, 10'd31, 5'd0, 1'b0, 1'b0, 11);

    // A start pulse mid-RUN is ignored and busy never drops.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 10'd100; bus.divisor = 5'd3;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      bus.start = (n == 4);
      if (n == 4) begin
        bus.dividend = 10'd50; bus.divisor = 5'd5;
      end
      if (bus.done === 1'b1) got = 1'b1;
      else chk("mid_busy", 32'(bus.busy), 32'd1);
    end
    chk("mid_latency", 32'(n), 32'd11);
    chk("mid_quotient", 32'(bus.quotient), 32'd33);
    chk("mid_remainder", 32'(bus.remainder), 32'd1);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // start held high: ignored in DONE, re-accepted in the following IDLE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 10'd143; bus.divisor = 5'd11;
    d0 = -1; d1 = -1; dn = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 24) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (dn == 0) d0 = k; else d1 = k;
        dn++;
      end
    end
    chk("b2b_count", 32'(dn), 32'd2);
    chk("b2b_first", 32'(d0), 32'd11);
    chk("b2b_second", 32'(d1), 32'd23);
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN abandons the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 10'd200; bus.divisor = 5'd9;
    repeat (7) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    dn = done_seen;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_quotient", 32'(bus.quotient), 32'd0);
    chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
    chk("mid_rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_done_after_rst", 32'(done_seen), 32'(dn));

    run_div(10'd200, 5'd9, 10'd22, 5'd2, 1'b0, 1'b0, 11);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
